// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester-side and uart_tx-side signal bundle for the shared
//               UART transmit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
) ();
  // requester side
  logic [N_REQ-1:0]   req_i;
  logic [8*N_REQ-1:0] data_i;
  logic [N_REQ-1:0]   last_i;
  logic [N_REQ-1:0]   ack_o;
  logic [N_REQ-1:0]   grant_o;
  logic               busy_o;
  // uart_tx side
  logic [7:0]         tx_data_o;
  logic               tx_valid_o;
  logic               tx_done_i;

  // arbiter view
  modport slave (
    input  req_i, data_i, last_i, tx_done_i,
    output ack_o, grant_o, busy_o, tx_data_o, tx_valid_o
  );

  // environment view (requesters + transmitter)
  modport master (
    output req_i, data_i, last_i, tx_done_i,
    input  ack_o, grant_o, busy_o, tx_data_o, tx_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one uart_tx byte transmitter
//               between N_REQ requesters, with packet locking and a
//               per-grant burst limit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rstn_i,
  uart_tx_arbiter_if.slave bus
);

  localparam int               PTR_W      = $clog2(N_REQ);
  localparam int               CNT_W      = $clog2(MAX_BURST) + 1;
  localparam logic [PTR_W-1:0] PTR_MAX    = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [PTR_W-1:0] ptr, ptr_d;
  logic [PTR_W-1:0] owner, owner_d;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_d;
  logic [7:0]       tx_data, tx_data_d;
  logic             last_q, last_d;
  logic             tx_valid;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;

  // (base + off) mod N_REQ, valid for off < N_REQ and any N_REQ
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return PTR_W'(sum);
  endfunction

  // round-robin search: first requester at or after ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && bus.req_i[wrap_add(ptr, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(ptr, k);
      end
    end
  end

  // next-state and datapath-latch decisions
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    owner_d     = owner;
    burst_cnt_d = burst_cnt;
    tx_data_d   = tx_data;
    last_d      = last_q;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          owner_d     = win_idx;
          tx_data_d   = bus.data_i[{win_idx, 3'b000} +: 8];
          last_d      = bus.last_i[win_idx];
          burst_cnt_d = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        // byte is held until the transmitter reports completion
        if (bus.tx_done_i) state_d = GAP;
      end
      GAP: begin
        // one idle cycle lets uart_tx re-arm before the next byte
        if (last_q || (burst_cnt == BURST_LAST) || !bus.req_i[owner]) begin
          ptr_d   = (owner == PTR_MAX) ? '0 : owner + 1'b1;
          state_d = IDLE;
        end else begin
          tx_data_d   = bus.data_i[{owner, 3'b000} +: 8];
          last_d      = bus.last_i[owner];
          burst_cnt_d = burst_cnt + 1'b1;
          state_d     = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; tx_valid registered to stay glitch-free
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      tx_data   <= '0;
      last_q    <= 1'b0;
      tx_valid  <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      owner     <= owner_d;
      burst_cnt <= burst_cnt_d;
      tx_data   <= tx_data_d;
      last_q    <= last_d;
      tx_valid  <= (state_d == SEND);
    end
  end

  // owner grant while active, ack pulse in the completing SEND cycle
  always_comb begin
    bus.grant_o = '0;
    bus.ack_o   = '0;
    if (state != IDLE) bus.grant_o[owner] = 1'b1;
    if ((state == SEND) && bus.tx_done_i) bus.ack_o[owner] = 1'b1;
  end

  assign bus.busy_o     = (state != IDLE);
  assign bus.tx_valid_o = tx_valid;
  assign bus.tx_data_o  = tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Scoreboard bench for uart_tx_arbiter: requester queues,
//               transmitter model and a transaction-level service-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int MB  = 4;
  localparam int NPH = 40;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  bit   spur_en = 1'b1;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .clk    (clk),
    .rstn_i (rstn),
    .bus    (bus.slave)
  );

  typedef struct {
    int         owner;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] pq[N][$];   // per-requester pending bytes {last, data}
  int         total = 0;
  int         bad   = 0;
  int         m_ptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Requesters: drop the acknowledged byte, present the next one
  task automatic drive_reqs(input logic [N-1:0] acked);
    logic [8:0] hd;
    for (int i = 0; i < N; i++) begin
      if (acked[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      if (pq[i].size() > 0) begin
        hd = pq[i][0];
        bus.req_i[i]         = 1'b1;
        bus.data_i[8*i +: 8] = hd[7:0];
        bus.last_i[i]        = hd[8];
      end else begin
        bus.req_i[i]  = 1'b0;
        bus.last_i[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_reqs(bus.ack_o);
  endtask

  // Service-order model: all queued bytes present at once, requesters stay
  // ready until their queue empties.
  task automatic predict();
    logic [8:0] mq[N][$];
    logic [8:0] e;
    int w, n;
    bit any;
    exp_t x;
    for (int i = 0; i < N; i++) mq[i] = pq[i];
    forever begin
      any = 1'b0;
      for (int i = 0; i < N; i++) if (mq[i].size() > 0) any = 1'b1;
      if (!any) break;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && mq[(m_ptr + k) % N].size() > 0) w = (m_ptr + k) % N;
      n = 0;
      do begin
        e = mq[w].pop_front();
        x.owner = w;
        x.data  = e[7:0];
        exp_q.push_back(x);
        n++;
      end while (!(e[8] || n == MB || mq[w].size() == 0));
      m_ptr = (w + 1) % N;
    end
  endtask

  task automatic start_phase();
    int first;
    predict();
    drive_reqs('0);
    if (exp_q.size() > 0) begin
      first = exp_q[0].owner;
      cycle();
      check("first_valid", 32'(bus.tx_valid_o), 32'd1);
      check("first_grant", 32'(bus.grant_o), 32'(1 << first));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy_o) && n < 2000) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(n < 2000), 32'd1);
    check("idle_busy", 32'(bus.busy_o), 32'd0);
    check("idle_grant", 32'(bus.grant_o), 32'd0);
    check("idle_req", 32'(bus.req_i), 32'd0);
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    pq[r].push_back({l, d});
  endtask

  // Transmitter model: done after a random number of SEND cycles,
  // occasional stray done pulses while the arbiter is not sending
  initial begin
    int dly;
    dly = 0;
    bus.tx_done_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        bus.tx_done_i = 1'b0;
        dly = $urandom_range(0, 3);
      end else if (bus.tx_valid_o) begin
        if (dly == 0) begin
          bus.tx_done_i = 1'b1;
          dly = $urandom_range(0, 3);
        end else begin
          bus.tx_done_i = 1'b0;
          dly--;
        end
      end else begin
        bus.tx_done_i = spur_en && ($urandom_range(0, 2) == 0);
      end
    end
  end

  // Monitor: every ack is matched against the next expected byte
  initial begin
    bit   prev_ack;
    exp_t e;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && prev_ack) begin
        check("gap_valid", 32'(bus.tx_valid_o), 32'd0);
        check("gap_busy", 32'(bus.busy_o), 32'd1);
      end
      prev_ack = 1'b0;
      if (bus.ack_o != '0) begin
        prev_ack = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(bus.ack_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_owner", 32'(bus.ack_o), 32'(1 << e.owner));
          check("ack_grant", 32'(bus.grant_o), 32'(1 << e.owner));
          check("ack_data", 32'(bus.tx_data_o), 32'(e.data));
        end
      end
    end
  end

  // Main stimulus sequence
  initial begin
    int acc;
    bus.req_i  = '0;
    bus.data_i = '0;
    bus.last_i = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.tx_valid_o), 32'd0);
    check("rst_grant", 32'(bus.grant_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_ack", 32'(bus.ack_o), 32'd0);
    check("rst_data", 32'(bus.tx_data_o), 32'd0);
    rstn = 1'b1;
    cycle();

    // all four single-byte requests: served 0,1,2,3
    for (int i = 0; i < N; i++) push(i, 8'(8'hA0 + i), 1'b1);
    start_phase();
    drain();

    // three-byte packet from requester 0
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h33, 1'b1);
    start_phase();
    drain();

    // move the pointer to 3, then check wrap-around order 3 before 0
    push(1, 8'h51, 1'b1);
    push(2, 8'h52, 1'b1);
    start_phase();
    drain();
    push(0, 8'h60, 1'b1);
    push(3, 8'h63, 1'b1);
    start_phase();
    drain();

    // stray tx_done while idle must not ack or wake the arbiter
    acc = 0;
    repeat (12) begin
      cycle();
      if (bus.ack_o != '0 || bus.busy_o) acc++;
    end
    check("idle_stray_done", 32'(acc), 32'd0);

    // reset in the middle of a SEND
    push(0, 8'h71, 1'b0);
    push(0, 8'h72, 1'b1);
    push(2, 8'h73, 1'b1);
    start_phase();
    #2 rstn = 1'b0;
    #1;
    check("arst_valid", 32'(bus.tx_valid_o), 32'd0);
    check("arst_grant", 32'(bus.grant_o), 32'd0);
    check("arst_busy", 32'(bus.busy_o), 32'd0);
    for (int i = 0; i < N; i++) pq[i].delete();
    exp_q.delete();
    drive_reqs('0);
    m_ptr = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cycle();
    push(1, 8'h81, 1'b1);
    push(2, 8'h82, 1'b1);
    start_phase();
    drain();

    // burst limit: 10-byte unterminated packet from 0, one byte from 1
    for (int b = 0; b < 10; b++) push(0, 8'(8'hC0 + b), 1'b0);
    push(1, 8'hD1, 1'b1);
    start_phase();
    drain();

    // randomized phases
    for (int p = 0; p < NPH; p++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          int len;
          len = $urandom_range(1, 10);
          for (int b = 0; b < len; b++) begin
            logic l;
            l = (b == len - 1) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 5) == 0);
            push(i, 8'($urandom), l);
          end
        end
      end
      start_phase();
      drain();
      repeat ($urandom_range(0, 4)) cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
